ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the core's single unified RAM port between the instruction-fetch requester and the data (load/store) requester. Each transaction is sequenced through a three-state controller: accept, hold until the RAM acknowledges, then return a one-cycle done pulse with read data to the winner. Fairness is round-robin when both requesters contend. It sits between the fetch/memory stages and the RAM wrapper.

## Interface
- `WORD_W`, 32: address and data width. Taken from the shared package, not overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `i_req` in 1: instruction-fetch request, level. Held until `i_done`.
- `i_addr` in WORD_W: fetch address.
- `i_done` out 1: one-cycle pulse; `i_rdata` is valid in this cycle.
- `i_rdata` out WORD_W: fetched word.
- `d_req` in 1: data request, level. Held until `d_done`.
- `d_wen` in 1: 1 = store, 0 = load.
- `d_addr` in WORD_W: data address.
- `d_wdata` in WORD_W: store data.
- `d_strobe` in 4: byte enables for a store. Ignored on a load.
- `d_done` out 1: one-cycle pulse; `d_rdata` is valid in this cycle (loads only).
- `d_rdata` out WORD_W: load data.
- `ram_en` out 1: RAM access active.
- `ram_wen` out 1: RAM write.
- `ram_addr` out WORD_W.
- `ram_wdata` out WORD_W.
- `ram_strobe` out 4.
- `ram_rdata` in WORD_W.
- `ram_ready` in 1: RAM completion; `ram_rdata` is valid in the same cycle.

## Operation
- **State machine.** Uses `ram_state_t`: `RAM_IDLE` → `RAM_WAIT` → `RAM_DONE` → `RAM_IDLE`.
- **RAM_IDLE.**
  - If any request is present, pick a winner and latch its owner, address, wdata, strobe and wen into registers. Next state is `RAM_WAIT`.
  - With no request, stay in `RAM_IDLE`.
- **Arbitration.**
  - A single requester wins unconditionally.
  - When both request, the winner is the port *not* granted last. A `last_d` flag is updated on each grant.
  - Reset value of `last_d` is 0, so data wins the first contention.
- **RAM_WAIT.**
  - `ram_en`=1 and the RAM outputs come from the latched registers.
  - `ram_wen`=latched wen. It is always 0 for the instruction port.
  - `ram_strobe`=latched strobe for a data store, otherwise 4'b0000.
  - When `ram_ready`=1, capture `ram_rdata` into the response register. Next state is `RAM_DONE`.
- **RAM_DONE.**
  - `ram_en`=0.
  - The owner's done output is 1 for exactly this cycle. The owner's rdata output shows the captured word.
  - Next state is `RAM_IDLE` unconditionally.
- **Response registers.** The `rdata` outputs hold their last value until the next capture. Data is valid only alongside done.
- **No cancellation.** If a requester drops `req` during `RAM_WAIT`, the access still completes and done still pulses.
- **Request/data relationship.** Request inputs are sampled only in `RAM_IDLE`. Later changes to addr or data do not affect the in-flight access.
- **No transformation.** There is no alignment check and no address transformation; widths pass straight through.

## Timing
- **Reset values.** All outputs are 0: `ram_en`, `ram_wen`, `ram_addr`, `ram_wdata`, `ram_strobe`, `i_done`, `d_done`, `i_rdata`, `d_rdata`. State is `RAM_IDLE` and `last_d`=0.
- **Latency.**
  - Request sampled in IDLE at edge N.
  - `ram_en` is high from cycle N+1.
  - `ram_ready` arrives at cycle N+k (k≥1).
  - done is high in cycle N+k+1.
  - Minimum request-to-done is 2 cycles past the sampling edge for k=1.
- **Throughput.** At most one transaction per 3 cycles (IDLE, WAIT, DONE).
- **Requester rule.** Deassert `req` on the edge that ends the done cycle. IDLE then sees the new level, so a fresh request may be asserted on that same edge.
- **Stray ready.** `ram_ready` outside `RAM_WAIT` is ignored.
- **Reset during an access.** Reset in WAIT or DONE goes to IDLE on the next edge. `ram_en` drops, no done is emitted, and `last_d` clears.
- **Outputs are registered or state-decoded only.** There is no combinational path from `*_req` or `ram_ready` to any output.

## Structure
- `ram_state_t` and `WORD_W` come from the shared common types package.
- Add a `ram_owner_t` enum (`OWNER_I`, `OWNER_D`) to the shared package.
- Single module, no sub-modules. The round-robin pick is a few lines inside it.

## Test plan
- **Single fetch.**
  - Stimulus: `i_req`=1, `i_addr`=0x100. The RAM asserts `ram_ready` with rdata 0xDEADBEEF 3 cycles after `ram_en` rises.
  - Required: `ram_en`=1 and `ram_wen`=0 with `ram_addr`=0x100 for 3 cycles. Then `i_done`=1 for 1 cycle with `i_rdata`=0xDEADBEEF; `d_done` stays 0.
- **Store.**
  - Stimulus: `d_req`=1, `d_wen`=1, addr 0x2004, wdata 0x12345678, strobe 4'b0011, 1-cycle RAM.
  - Required: RAM sees exactly those values for one cycle, then `d_done` pulses once.
- **Contention.**
  - Stimulus: both requests held continuously from reset.
  - Required: grants alternate D, I, D, I. Each done pulse is followed two cycles later by `ram_en` for the other port.
- **Mid-flight changes.**
  - Stimulus: in WAIT, change `d_addr` and drop `d_req`.
  - Required: `ram_addr` keeps the latched value and `d_done` still pulses.
- **Reset mid-access.**
  - Stimulus: assert `rst` in WAIT.
  - Required: the next cycle has `ram_en`=0 and no done pulse. The next contention grants data first.
- **Stray ready.**
  - Stimulus: `ram_ready`=1 while IDLE.
  - Required: no state change and no done pulse.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the unified RAM port arbiter: word width, controller states,
// port ownership and the round-robin pick.
package ram_arbiter_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_DONE = 2'd2
    } ram_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } ram_owner_t;

    // Under contention the port not granted last wins; last_d=0 favours data.
    function automatic ram_owner_t rr_pick(input logic i_req, input logic d_req,
                                           input logic last_d);
        if (i_req && d_req) begin
            return last_d ? OWNER_I : OWNER_D;
        end else if (d_req) begin
            return OWNER_D;
        end else begin
            return OWNER_I;
        end
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Shares one RAM port between instruction fetch and data access. Each access runs
// IDLE -> WAIT -> DONE; all outputs are registered.
module ram_arbiter
    import ram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic              i_done,
    output logic [WORD_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_wen,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    input  logic [STRB_W-1:0] d_strobe,
    output logic              d_done,
    output logic [WORD_W-1:0] d_rdata,

    output logic              ram_en,
    output logic              ram_wen,
    output logic [WORD_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    output logic [STRB_W-1:0] ram_strobe,
    input  logic [WORD_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    ram_state_t state;
    ram_owner_t owner;
    ram_owner_t grant;
    logic       last_d;

    always_comb begin
        grant = rr_pick(i_req, d_req, last_d);
    end

    // ram_addr/ram_wdata double as the latched request; they hold after completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RAM_IDLE;
            owner      <= OWNER_I;
            last_d     <= 1'b0;
            ram_en     <= 1'b0;
            ram_wen    <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_strobe <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                RAM_IDLE: begin
                    if (i_req || d_req) begin
                        state  <= RAM_WAIT;
                        owner  <= grant;
                        last_d <= (grant == OWNER_D);
                        ram_en <= 1'b1;
                        if (grant == OWNER_D) begin
                            ram_addr   <= d_addr;
                            ram_wdata  <= d_wdata;
                            ram_wen    <= d_wen;
                            ram_strobe <= d_wen ? d_strobe : '0;
                        end else begin
                            ram_addr   <= i_addr;
                            ram_wdata  <= '0;
                            ram_wen    <= 1'b0;
                            ram_strobe <= '0;
                        end
                    end
                end
                RAM_WAIT: begin
                    if (ram_ready) begin
                        state      <= RAM_DONE;
                        ram_en     <= 1'b0;
                        ram_wen    <= 1'b0;
                        ram_strobe <= '0;
                        if (owner == OWNER_D) begin
                            d_rdata <= ram_rdata;
                            d_done  <= 1'b1;
                        end else begin
                            i_rdata <= ram_rdata;
                            i_done  <= 1'b1;
                        end
                    end
                end
                RAM_DONE: begin
                    state <= RAM_IDLE;
                end
                default: begin
                    state <= RAM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized bench for ram_arbiter; the bench plays both requesters
// and the RAM, and predicts each transaction from the arbitration rules.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req, d_req, d_wen, ram_ready;
    logic [WORD_W-1:0] i_addr, d_addr, d_wdata, ram_rdata;
    logic [STRB_W-1:0] d_strobe;
    logic              i_done, d_done, ram_en, ram_wen;
    logic [WORD_W-1:0] i_rdata, d_rdata, ram_addr, ram_wdata;
    logic [STRB_W-1:0] ram_strobe;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: who was granted last, and what each rdata output should hold.
    bit                last_was_d = 1'b0;
    logic [WORD_W-1:0] exp_i_rdata = '0;
    logic [WORD_W-1:0] exp_d_rdata = '0;

    ram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_done     (i_done),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_wen      (d_wen),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_strobe   (d_strobe),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .ram_en     (ram_en),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_strobe (ram_strobe),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_idone"}, 32'(i_done), 32'd0);
        chk({tag, "_ddone"}, 32'(d_done), 32'd0);
        chk({tag, "_irdata"}, i_rdata, exp_i_rdata);
        chk({tag, "_drdata"}, d_rdata, exp_d_rdata);
    endtask

    // Called in an IDLE cycle with the request inputs already set; runs one full
    // transaction with a k-cycle RAM and ends in the following IDLE cycle.
    task automatic episode(input int k, input logic [31:0] rd, input bit keep,
                           input bit drop_mid);
        bit          win_d;
        logic [31:0] e_addr, e_wdata;
        logic        e_wen;
        logic [3:0]  e_strb;
        if (i_req && d_req) win_d = !last_was_d;
        else                win_d = d_req;
        last_was_d = win_d;
        e_addr  = win_d ? d_addr : i_addr;
        e_wen   = win_d && d_wen;
        e_strb  = e_wen ? d_strobe : 4'h0;
        e_wdata = d_wdata;
        tick();
        for (int c = 1; c <= k; c++) begin
            chk("wait_en", 32'(ram_en), 32'd1);
            chk("wait_addr", ram_addr, e_addr);
            chk("wait_wen", 32'(ram_wen), 32'(e_wen));
            chk("wait_strobe", 32'(ram_strobe), 32'(e_strb));
            if (e_wen) chk("wait_wdata", ram_wdata, e_wdata);
            chk("wait_idone", 32'(i_done), 32'd0);
            chk("wait_ddone", 32'(d_done), 32'd0);
            // The in-flight access must ignore any input change from here on.
            i_addr   = $urandom;
            d_addr   = $urandom;
            d_wdata  = $urandom;
            d_strobe = 4'($urandom);
            d_wen    = 1'($urandom);
            if (drop_mid) begin
                if (win_d) d_req = 1'b0;
                else       i_req = 1'b0;
            end
            ram_ready = (c == k);
            ram_rdata = (c == k) ? rd : $urandom;
            tick();
        end
        ram_ready = 1'b0;
        ram_rdata = $urandom;
        if (win_d) exp_d_rdata = rd;
        else       exp_i_rdata = rd;
        chk("done_idone", 32'(i_done), 32'(!win_d));
        chk("done_ddone", 32'(d_done), 32'(win_d));
        chk("done_irdata", i_rdata, exp_i_rdata);
        chk("done_drdata", d_rdata, exp_d_rdata);
        chk("done_en", 32'(ram_en), 32'd0);
        if (!keep) begin
            if (win_d) d_req = 1'b0;
            else       i_req = 1'b0;
        end
        tick();
        chk_quiet("idle");
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0; ram_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_strobe = '0; ram_rdata = '0;
        tick();
        tick();
        chk("rst_wen", 32'(ram_wen), 32'd0);
        chk("rst_addr", ram_addr, 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_strobe", 32'(ram_strobe), 32'd0);
        chk_quiet("rst");
        rst = 1'b0;
        tick();
        chk_quiet("post_rst");

        // Single fetch, 3-cycle RAM.
        i_req = 1'b1; i_addr = 32'h100;
        episode(3, 32'hDEADBEEF, 1'b0, 1'b0);

        // Byte-strobed store, 1-cycle RAM.
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h2004; d_wdata = 32'h12345678;
        d_strobe = 4'b0011;
        episode(1, $urandom, 1'b0, 1'b0);

        // Contention from reset: expect D, I, D, I.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_was_d = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
        chk_quiet("cont_rst");
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h400; d_addr = 32'h800; d_wen = 1'b0;
        for (int n = 0; n < 4; n++) episode(1 + n % 2, $urandom, 1'b1, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk_quiet("cont_end");

        // Address change and request drop mid-flight.
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h3000;
        episode(2, 32'hCAFEF00D, 1'b0, 1'b1);

        // Reset while a data access waits: no done, and data wins the next contention.
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h3100; d_strobe = 4'hF;
        tick();
        chk("rstmid_en", 32'(ram_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_req = 1'b0;
        last_was_d = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
        chk_quiet("rstmid");
        tick();
        chk_quiet("rstmid2");
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h500; d_addr = 32'h600; d_wen = 1'b0;
        episode(1, $urandom, 1'b0, 1'b0);
        chk("rstmid_iheld", 32'(i_req), 32'd1);
        episode(1, $urandom, 1'b0, 1'b0);

        // Stray ready while idle.
        ram_ready = 1'b1;
        tick();
        chk_quiet("stray1");
        tick();
        chk_quiet("stray2");
        ram_ready = 1'b0;
        tick();
        chk_quiet("stray3");

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            i_req    = i_req | 1'($urandom);
            d_req    = d_req | 1'($urandom);
            i_addr   = $urandom;
            d_addr   = $urandom;
            d_wdata  = $urandom;
            d_strobe = 4'($urandom);
            d_wen    = 1'($urandom);
            ram_ready = 1'($urandom);
            ram_rdata = $urandom;
            if (!i_req && !d_req) begin
                tick();
                chk_quiet("rnd_idle");
            end else begin
                episode(int'($urandom_range(1, 4)), $urandom, 1'($urandom),
                        $urandom_range(0, 3) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
